// File: rtl/reg_6_8b_tx_if.sv
// Frame-request / UART line bundle between the time source and the 6-byte transmitter.
// master drives the request and payload; slave is the transmitter itself.
interface reg_6_8b_tx_if;
    logic [5:0][7:0] time_reg;
    logic            send;
    logic            tx;
    logic            busy;
    logic            done;

    modport master (output time_reg, output send, input tx, input busy, input done);
    modport slave  (input time_reg, input send, output tx, output busy, output done);
endinterface

// File: rtl/reg_6_8b_tx.sv
// UART transmitter for the 6-byte time frame: sends 'r', time_reg[0..5], 't'
// as eight back-to-back 8N1 characters, each bit BIT_CYCLES clocks long.
module reg_6_8b_tx #(
    parameter int unsigned baudrate = 9600,
    parameter int unsigned clk_frec = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    reg_6_8b_tx_if.slave bus
);
    localparam int unsigned BIT_CYCLES = clk_frec / baudrate;
    localparam int unsigned BAUD_W     = $clog2(BIT_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [7:0] HEAD = 8'h72;
    localparam logic [7:0] TAIL = 8'h74;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0][7:0]   pay_q, pay_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [7:0]        byte_cur;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // Frame byte idx 0 and 7 are the fixed markers; 1..6 come from the latched payload.
    always_comb begin
        byte_cur = pay_q[idx_q - 3'd1];
        if (idx_q == 3'd0) byte_cur = HEAD;
        if (idx_q == 3'd7) byte_cur = TAIL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            pay_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            pay_q   <= pay_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        pay_d   = pay_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    pay_d   = bus.time_reg;
                    state_d = START;
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = byte_cur[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_cur[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_reg_6_8b_tx.sv
// Unit bench for reg_6_8b_tx at BIT_CYCLES=10: a line decoder pops expected
// characters from a scoreboard queue filled when each frame is requested.
module tb_reg_6_8b_tx;
    localparam int BC    = 10;
    localparam int FRAME = 80 * BC;

    logic clk = 1'b0;
    logic rst;

    reg_6_8b_tx_if bus ();

    reg_6_8b_tx #(.baudrate(1000000), .clk_frec(10000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) if (!rst && bus.done === 1'b1) done_cnt++;

    // Line decoder: negedge samples, 10 per bit; every sample in a bit must agree.
    bit         dec_active = 1'b0;
    bit         dec_bad;
    int         dec_cnt;
    logic       bit_val;
    logic [7:0] dec_byte;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (bus.tx === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
                dec_bad    = 1'b0;
                bit_val    = 1'b0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % BC == 0) bit_val = bus.tx;
            else if (bus.tx !== bit_val) dec_bad = 1'b1;
            if (dec_cnt >= BC && dec_cnt < 9 * BC && dec_cnt % BC == BC / 2)
                dec_byte[dec_cnt / BC - 1] = bus.tx;
            if (dec_cnt == 9 * BC + BC / 2) begin
                dec_active = 1'b0;
                tests++;
                if (dec_bad || bus.tx !== 1'b1) begin
                    fails++;
                    $display("FAIL char_framing: unstable_bit=%0d stop=%b, required stable bits and stop=1",
                             dec_bad, bus.tx);
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL char_unexpected: got %02h, required no character", dec_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (dec_byte !== exp_b) begin
                        fails++;
                        $display("FAIL char_value: got %02h, required %02h", dec_byte, exp_b);
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [5:0][7:0] p);
        exp_q.push_back(8'h72);
        for (int i = 0; i < 6; i++) exp_q.push_back(p[i]);
        exp_q.push_back(8'h74);
    endtask

    task automatic send_pulse();
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic wait_busy_end(input int limit, output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        rst          = 1'b1;
        bus.send     = 1'b0;
        bus.time_reg = '0;
        for (int i = 0; i < 5; i++) begin
            bus.send = (i >= 1 && i <= 3);
            @(negedge clk);
            tests++;
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
                fails++;
                $display("FAIL reset_state: tx/busy/done=%b, required 100", {bus.tx, bus.busy, bus.done});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL idle_quiet: line activity seen=%0d, required 0", bad);
        end
        tests++;
        if (done_cnt !== 0) begin
            fails++;
            $display("FAIL idle_done: done count %0d, required 0", done_cnt);
        end
    endtask

    task automatic test_frame();
        logic [5:0][7:0] p;
        int cyc;
        int d0 = done_cnt;
        for (int i = 0; i < 6; i++) p[i] = 8'(30 + i);
        bus.time_reg = p;
        push_frame(p);
        send_pulse();
        tests++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            fails++;
            $display("FAIL accept: busy=%b tx=%b, required busy=1 tx=0", bus.busy, bus.tx);
        end
        wait_busy_end(2 * FRAME, cyc);
        tests++;
        if (cyc !== FRAME) begin
            fails++;
            $display("FAIL busy_len: got %0d cycles, required %0d", cyc, FRAME);
        end
        tests++;
        if (bus.done !== 1'b1 || bus.tx !== 1'b1) begin
            fails++;
            $display("FAIL end_pulse: done=%b tx=%b, required done=1 tx=1", bus.done, bus.tx);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL done_width: done=%b one cycle later, required 0", bus.done);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL frame_done_cnt: got %0d, required 1", done_cnt - d0);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL frame_chars: %0d characters missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_ignore_send();
        logic [5:0][7:0] p, p2;
        int d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            p[i]  = 8'(30 + i);
            p2[i] = 8'(33 + i);
        end
        bus.time_reg = p;
        push_frame(p);
        send_pulse();
        for (int c = 1; c < FRAME + 60; c++) begin
            @(negedge clk);
            bus.send = (c == 50 || c == 400);
            if (c == 200) bus.time_reg = p2;
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            fails++;
            $display("FAIL ignore_requeue: busy=%b tx=%b, required busy=0 tx=1", bus.busy, bus.tx);
        end
        tests++;
        if (done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL ignore_done_cnt: got %0d, required 1", done_cnt - d0);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL ignore_chars: %0d characters missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0][7:0] p;
        int n = 0;
        int cyc;
        int d0 = done_cnt;
        for (int i = 0; i < 6; i++) p[i] = 8'(33 + i);
        bus.time_reg = p;
        push_frame(p);
        push_frame(p);
        @(negedge clk);
        bus.send = 1'b1;
        while (bus.done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first_end: done=%b busy=%b tx=%b after %0d cycles, required 1/0/1",
                     bus.done, bus.busy, bus.tx, n);
        end
        @(negedge clk);
        bus.send = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b tx=%b, required busy=1 tx=0", bus.busy, bus.tx);
        end
        wait_busy_end(2 * FRAME, cyc);
        tests++;
        if (cyc !== FRAME || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_len: got %0d cycles done=%b, required %0d cycles done=1",
                     cyc, bus.done, FRAME);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 2) begin
            fails++;
            $display("FAIL b2b_done_cnt: got %0d, required 2", done_cnt - d0);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL b2b_chars: %0d characters missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0][7:0] p;
        int cyc;
        int d0;
        for (int i = 0; i < 6; i++) p[i] = 8'(30 + i);
        bus.time_reg = p;
        push_frame(p);
        send_pulse();
        repeat (340) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: tx=%b busy=%b done=%b, required 1/0/0", bus.tx, bus.busy, bus.done);
        end
        tests++;
        if (exp_q.size() !== 5) begin
            fails++;
            $display("FAIL mid_reset_chars: %0d characters pending, required 5", exp_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (50) @(negedge clk);
        tests++;
        if (done_cnt !== d0 || bus.tx !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_quiet: done delta %0d tx=%b, required 0 and tx=1", done_cnt - d0, bus.tx);
        end
        for (int i = 0; i < 6; i++) p[i] = 8'($urandom_range(0, 255));
        bus.time_reg = p;
        push_frame(p);
        send_pulse();
        wait_busy_end(2 * FRAME, cyc);
        tests++;
        if (cyc !== FRAME) begin
            fails++;
            $display("FAIL post_reset_len: got %0d cycles, required %0d", cyc, FRAME);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL post_reset_frame: done delta %0d pending %0d, required 1 and 0",
                     done_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ignore_send();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
